ascii_ps2_transmitter: RTL and testbench

- Device-side PS/2 keyboard transmitter: the encode/transmit counterpart of the PS/2 Set 2 scan-code-to-ASCII path.
- Accepts one ASCII character per valid/ready handshake and maps it to its Set 2 make code.
- Serialises three PS/2 frames onto generated ps2_clk/ps2_data lines: make, 8'hF0, make (a full keypress/release).
- Used as a keyboard emulator to drive the PS/2 receive chain in loopback and self-test.

---
 rtl/ascii_ps2_transmitter.sv | 237 +++++++++++++++++++++++
 tb/tb_ascii_ps2_transmitter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_ps2_transmitter.sv
// ascii_ps2_transmitter
// Device-side PS/2 keyboard emulator. Each accepted ASCII character is
// mapped to its Set 2 make code and sent as a complete keypress/release:
// three 11-bit frames (make, F0, make). Each frame is followed by an idle
// gap with both lines high. ps2_data only changes while ps2_clk is high, so
// a host receiver can sample the data on the falling edges of ps2_clk.
module ascii_ps2_transmitter #(
  parameter int HALF_PERIOD = 2000,  // clk cycles per PS/2 clock half-phase, >= 2
  parameter int GAP_CYCLES  = 5000   // idle cycles after every frame, >= 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       unsupported
);

  // One counter serves both the half-phase timer and the gap timer, so it
  // is sized for the larger of the two intervals.
  localparam int CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [7:0]    BREAK_CODE = 8'hF0;
  localparam logic [3:0]    STOP_BIT   = 4'd10;
  localparam logic [1:0]    LAST_FRAME = 2'd2;
  localparam logic [1:0]    BREAK_IDX  = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_FRAME_HI = 3'd2,
    S_FRAME_LO = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  // Set 2 make code lookup: returns {supported, code}.
  function automatic logic [8:0] map_ascii(input logic [7:0] c);
    logic [8:0] r;
    case (c)
      8'h30:        r = {1'b1, 8'h45};
      8'h31:        r = {1'b1, 8'h16};
      8'h32:        r = {1'b1, 8'h1E};
      8'h33:        r = {1'b1, 8'h26};
      8'h34:        r = {1'b1, 8'h25};
      8'h35:        r = {1'b1, 8'h2E};
      8'h36:        r = {1'b1, 8'h36};
      8'h37:        r = {1'b1, 8'h3D};
      8'h38:        r = {1'b1, 8'h3E};
      8'h39:        r = {1'b1, 8'h46};
      8'h41, 8'h61: r = {1'b1, 8'h1C};
      8'h42, 8'h62: r = {1'b1, 8'h32};
      8'h43, 8'h63: r = {1'b1, 8'h21};
      8'h44, 8'h64: r = {1'b1, 8'h23};
      8'h45, 8'h65: r = {1'b1, 8'h24};
      8'h46, 8'h66: r = {1'b1, 8'h2B};
      8'h0D:        r = {1'b1, 8'h5A};
      default:      r = {1'b0, 8'h00};
    endcase
    return r;
  endfunction

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Line level for bit position idx of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic v;
    case (idx)
      4'd0:                                    v = 1'b0;              // start
      4'd1, 4'd2, 4'd3, 4'd4,
      4'd5, 4'd6, 4'd7, 4'd8:                  v = b[3'(idx - 4'd1)]; // data, LSB first
      4'd9:                                    v = odd_parity(b);
      4'd10:                                   v = 1'b1;              // stop
      default:                                 v = 1'b1;
    endcase
    return v;
  endfunction

  state_t          state_r;
  logic [7:0]      code_r;
  logic [CW-1:0]   cnt_r;
  logic [3:0]      bit_r;
  logic [1:0]      frame_r;
  logic            ready_r;
  logic            ps2_clk_r;
  logic            ps2_data_r;
  logic            busy_r;
  logic            unsupported_r;

  logic [8:0]      map_s;
  logic [7:0]      frame_byte_s;
  logic [3:0]      next_bit_s;
  logic            phase_done_s;

  // Mapping of the incoming character, current frame byte and phase timer expiry.
  always_comb begin
    map_s        = map_ascii(ascii_in);
    frame_byte_s = code_r;
    next_bit_s   = bit_r + 4'd1;
    phase_done_s = 1'b0;
    if (frame_r == BREAK_IDX) begin
      frame_byte_s = BREAK_CODE;
    end else begin
      frame_byte_s = code_r;
    end
    case (state_r)
      S_FRAME_HI, S_FRAME_LO: phase_done_s = (cnt_r == HALF_LAST);
      S_GAP:                  phase_done_s = (cnt_r == GAP_LAST);
      default:                phase_done_s = 1'b0;
    endcase
  end

  // Transfer sequencer: handshake, lookup, three frames with gaps; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      code_r        <= 8'h00;
      cnt_r         <= '0;
      bit_r         <= 4'd0;
      frame_r       <= 2'd0;
      ready_r       <= 1'b1;
      ps2_clk_r     <= 1'b1;
      ps2_data_r    <= 1'b1;
      busy_r        <= 1'b0;
      unsupported_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          cnt_r      <= '0;
          ps2_clk_r  <= 1'b1;
          ps2_data_r <= 1'b1;
          if (ascii_valid && ready_r) begin
            // The lookup result is captured with the character, so an
            // unsupported character is flagged during the LOOKUP cycle.
            code_r        <= map_s[7:0];
            unsupported_r <= ~map_s[8];
            ready_r       <= 1'b0;
            busy_r        <= 1'b1;
            state_r       <= S_LOOKUP;
          end else begin
            unsupported_r <= 1'b0;
            ready_r       <= 1'b1;
            busy_r        <= 1'b0;
          end
        end

        S_LOOKUP: begin
          unsupported_r <= 1'b0;
          cnt_r         <= '0;
          if (unsupported_r) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            frame_r    <= 2'd0;
            bit_r      <= 4'd0;
            ps2_clk_r  <= 1'b1;
            ps2_data_r <= frame_bit(code_r, 4'd0);
            state_r    <= S_FRAME_HI;
          end
        end

        S_FRAME_HI: begin
          if (phase_done_s) begin
            cnt_r     <= '0;
            ps2_clk_r <= 1'b0;
            state_r   <= S_FRAME_LO;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end

        S_FRAME_LO: begin
          if (phase_done_s) begin
            cnt_r     <= '0;
            ps2_clk_r <= 1'b1;
            if (bit_r == STOP_BIT) begin
              ps2_data_r <= 1'b1;
              state_r    <= S_GAP;
            end else begin
              // Data advances together with the rising clock edge.
              bit_r      <= next_bit_s;
              ps2_data_r <= frame_bit(frame_byte_s, next_bit_s);
              state_r    <= S_FRAME_HI;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end

        S_GAP: begin
          if (phase_done_s) begin
            cnt_r <= '0;
            if (frame_r == LAST_FRAME) begin
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= S_IDLE;
            end else begin
              // Every frame opens with the start bit regardless of its byte.
              frame_r    <= frame_r + 2'd1;
              bit_r      <= 4'd0;
              ps2_data_r <= frame_bit(frame_byte_s, 4'd0);
              state_r    <= S_FRAME_HI;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end

        default: begin
          state_r       <= S_IDLE;
          cnt_r         <= '0;
          ready_r       <= 1'b1;
          busy_r        <= 1'b0;
          unsupported_r <= 1'b0;
          ps2_clk_r     <= 1'b1;
          ps2_data_r    <= 1'b1;
        end
      endcase
    end
  end

  assign ascii_ready = ready_r;
  assign ps2_clk     = ps2_clk_r;
  assign ps2_data    = ps2_data_r;
  assign busy        = busy_r;
  assign unsupported = unsupported_r;

endmodule

// File: tb/tb_ascii_ps2_transmitter.sv
// Testbench for ascii_ps2_transmitter: drives characters through the
// valid/ready handshake, captures ps2_data at every ps2_clk falling edge
// and compares frames, timing and handshake behaviour with a reference
// model built from the character table and frame format.
module tb_ascii_ps2_transmitter;

  localparam int HP        = 4;
  localparam int GAP       = 8;
  localparam int FRAME_CYC = 22 * HP;
  localparam int XFER      = 3 * (FRAME_CYC + GAP);

  localparam logic [7:0] DIGIT_CODE [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                             8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] HEX_CODE   [6]  = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
  localparam logic [7:0] SUP_CHARS  [17] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                                             8'h36, 8'h37, 8'h38, 8'h39, 8'h41, 8'h42,
                                             8'h43, 8'h44, 8'h45, 8'h46, 8'h0D};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ascii_in;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       unsupported;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ascii_ps2_transmitter #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .ascii_in    (ascii_in),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .busy        (busy),
    .unsupported (unsupported)
  );

  always #5 clk = ~clk;

  // Cycle number: cycle n runs from the posedge that sets cyc=n to the next posedge.
  always @(posedge clk) cyc <= cyc + 1;

  // Host-side receiver: captures data at ps2_clk falls, flags data moving while clock low.
  logic prev_clk  = 1'b1;
  logic prev_data = 1'b1;
  logic rx_bits [$];
  int   rx_time [$];
  int   fall_cnt  = 0;
  int   data_viol = 0;
  always @(negedge clk) begin
    if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
      rx_bits.push_back(ps2_data);
      rx_time.push_back(cyc);
      fall_cnt <= fall_cnt + 1;
    end
    if (ps2_data !== prev_data && ps2_clk !== 1'b1) data_viol <= data_viol + 1;
    prev_clk  <= ps2_clk;
    prev_data <= ps2_data;
  end

  // Reference: {supported, make code} for a character.
  function automatic logic [8:0] model_map(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, DIGIT_CODE[c - 8'h30]};
    if (c >= 8'h41 && c <= 8'h46) return {1'b1, HEX_CODE[c - 8'h41]};
    if (c >= 8'h61 && c <= 8'h66) return {1'b1, HEX_CODE[c - 8'h61]};
    if (c == 8'h0D) return {1'b1, 8'h5A};
    return 9'h000;
  endfunction

  // Reference frame, index i = i-th bit on the wire.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic handshake(input logic [7:0] c, output int t, output int base, output int vbase);
    int w;
    w = 0;
    @(negedge clk);
    while (ascii_ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (ascii_ready !== 1'b1) begin
      $display("FAIL ready_wait: ascii_ready=%b required 1", ascii_ready);
      bad++;
    end
    base        = rx_bits.size();
    vbase       = data_viol;
    ascii_in    = c;
    ascii_valid = 1'b1;
    t           = cyc;
    @(negedge clk);
    ascii_valid = 1'b0;
  endtask

  task automatic wait_done(output int ready_at, output int busy_n);
    int w;
    w      = 0;
    busy_n = 0;
    while (ascii_ready !== 1'b1 && w < 4000) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      w++;
    end
    ready_at = cyc;
    total++;
    if (ascii_ready !== 1'b1) begin
      $display("FAIL done_timeout: ascii_ready=%b required 1", ascii_ready);
      bad++;
    end
  endtask

  task automatic check_frames(input logic [7:0] c, input int t, input int base,
                              input string name, output logic [10:0] f0);
    logic [8:0]  m;
    logic [10:0] obs;
    logic [10:0] expv;
    int          late;
    int          idx;
    m  = model_map(c);
    f0 = '1;
    total++;
    if (rx_bits.size() - base != 33) begin
      $display("FAIL %s edge_count: got %0d required 33", name, rx_bits.size() - base);
      bad++;
    end
    for (int f = 0; f < 3; f++) begin
      expv = model_frame((f == 1) ? 8'hF0 : m[7:0]);
      obs  = '1;
      late = 0;
      for (int i = 0; i < 11; i++) begin
        idx = base + f * 11 + i;
        if (idx < rx_bits.size()) begin
          obs[i] = rx_bits[idx];
          if (rx_time[idx] != t + 2 + f * (FRAME_CYC + GAP) + i * 2 * HP + HP) late++;
        end else begin
          late++;
        end
      end
      if (f == 0) f0 = obs;
      total++;
      if (obs !== expv) begin
        $display("FAIL %s frame%0d: got %b required %b", name, f, obs, expv);
        bad++;
      end
      total++;
      if (late != 0) begin
        $display("FAIL %s frame%0d_timing: %0d misplaced edges, required 0", name, f, late);
        bad++;
      end
    end
  endtask

  task automatic check_transfer(input logic [7:0] c, input int t, input int base,
                                input int vbase, input string name, output logic [10:0] f0);
    int ready_at;
    int busy_n;
    wait_done(ready_at, busy_n);
    total++;
    if (ready_at != t + 2 + XFER) begin
      $display("FAIL %s ready_return: cycle %0d required %0d", name, ready_at, t + 2 + XFER);
      bad++;
    end
    total++;
    if (busy_n != 1 + XFER) begin
      $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_n, 1 + XFER);
      bad++;
    end
    check_frames(c, t, base, name, f0);
    total++;
    if (data_viol - vbase != 0) begin
      $display("FAIL %s data_while_clk_low: %0d changes required 0", name, data_viol - vbase);
      bad++;
    end
  endtask

  task automatic check_unsupported(input logic [7:0] c, input int base);
    int line_bad;
    total++;
    if ({unsupported, ascii_ready, busy, ps2_clk, ps2_data} !== 5'b10111) begin
      $display("FAIL unsup_t1 char=%h: {uns,rdy,busy,clk,data}=%b required 10111",
               c, {unsupported, ascii_ready, busy, ps2_clk, ps2_data});
      bad++;
    end
    @(negedge clk);
    total++;
    if ({unsupported, ascii_ready, busy} !== 3'b010) begin
      $display("FAIL unsup_t2 char=%h: {uns,rdy,busy}=%b required 010",
               c, {unsupported, ascii_ready, busy});
      bad++;
    end
    line_bad = 0;
    repeat (10) begin
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || unsupported !== 1'b0) line_bad++;
      @(negedge clk);
    end
    total++;
    if (line_bad != 0 || rx_bits.size() != base) begin
      $display("FAIL unsup_quiet char=%h: %0d bad cycles, %0d edges, required 0/0",
               c, line_bad, rx_bits.size() - base);
      bad++;
    end
  endtask

  task automatic run_char(input logic [7:0] c, input string name);
    int t, base, vbase;
    logic [10:0] f0;
    logic [8:0]  m;
    m = model_map(c);
    handshake(c, t, base, vbase);
    if (m[8]) check_transfer(c, t, base, vbase, name, f0);
    else      check_unsupported(c, base);
  endtask

  task automatic test_reset;
    rst         = 1'b1;
    ascii_valid = 1'b0;
    ascii_in    = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({ps2_clk, ps2_data, ascii_ready, busy, unsupported} !== 5'b11100) begin
      $display("FAIL reset: {clk,data,rdy,busy,uns}=%b required 11100",
               {ps2_clk, ps2_data, ascii_ready, busy, unsupported});
      bad++;
    end
    rst = 1'b0;
  endtask

  task automatic test_char_1;
    int t, base, vbase;
    logic [10:0] f0;
    handshake(8'h31, t, base, vbase);
    check_transfer(8'h31, t, base, vbase, "char_1", f0);
    total++;
    if (f0 !== 11'b10000101100) begin
      $display("FAIL char_1 literal_frame0: got %b required 10000101100", f0);
      bad++;
    end
  endtask

  task automatic test_enter_and_nine;
    int t, base, vbase;
    logic [10:0] f0;
    handshake(8'h0D, t, base, vbase);
    check_transfer(8'h0D, t, base, vbase, "enter", f0);
    total++;
    if (f0[8:1] !== 8'h5A || f0[9] !== 1'b1) begin
      $display("FAIL enter_literal: byte=%h parity=%b required 5a/1", f0[8:1], f0[9]);
      bad++;
    end
    handshake(8'h39, t, base, vbase);
    check_transfer(8'h39, t, base, vbase, "nine", f0);
    total++;
    if (f0[8:1] !== 8'h46 || f0[9] !== 1'b0) begin
      $display("FAIL nine_literal: byte=%h parity=%b required 46/0", f0[8:1], f0[9]);
      bad++;
    end
  endtask

  task automatic test_back_to_back;
    int t1, t2, base1, ready_at, w, early;
    logic [10:0] f0;
    @(negedge clk);
    base1       = rx_bits.size();
    ascii_in    = 8'h61;
    ascii_valid = 1'b1;
    t1          = cyc;
    @(negedge clk);
    ascii_in = 8'h35;      // presented while busy, must never be sampled
    early    = 0;
    w        = 0;
    while (ascii_ready !== 1'b1 && w < 4000) begin
      if (cyc == t1 + 250) ascii_in = 8'h41;
      if (unsupported !== 1'b0) early++;
      @(negedge clk);
      w++;
    end
    ready_at = cyc;
    total++;
    if (ready_at != t1 + 2 + XFER || early != 0) begin
      $display("FAIL b2b_first_ready: cycle %0d uns_pulses %0d required %0d/0",
               ready_at, early, t1 + 2 + XFER);
      bad++;
    end
    t2 = cyc;              // valid still high: second handshake in this cycle
    @(negedge clk);
    ascii_valid = 1'b0;
    check_frames(8'h61, t1, base1, "b2b_a", f0);
    check_transfer(8'h41, t2, base1 + 33, data_viol, "b2b_A", f0);
  endtask

  task automatic test_unsupported;
    logic [7:0] c;
    logic [8:0] m;
    run_char(8'h47, "unsup_G");
    for (int k = 0; k < 5; k++) begin
      do begin
        c = 8'($urandom_range(0, 255));
        m = model_map(c);
      end while (m[8]);
      run_char(c, "unsup_rand");
    end
  endtask

  task automatic test_random;
    logic [7:0] c;
    int idx;
    for (int k = 0; k < 10; k++) begin
      idx = int'($urandom_range(0, 16));
      c   = SUP_CHARS[idx];
      if (c >= 8'h41 && c <= 8'h46 && $urandom_range(0, 1) == 1) c = c + 8'h20;
      if ($urandom_range(0, 3) == 0) c = 8'($urandom_range(0, 255));
      run_char(c, "random");
    end
  endtask

  task automatic test_loopback;
    int t, base, vbase;
    logic [10:0] f0;
    logic [7:0]  dec;
    logic [8:0]  m;
    for (int k = 0; k < 17; k++) begin
      handshake(SUP_CHARS[k], t, base, vbase);
      check_transfer(SUP_CHARS[k], t, base, vbase, "loopback", f0);
      dec = 8'h00;
      for (int j = 16; j >= 0; j--) begin
        m = model_map(SUP_CHARS[j]);
        if (m[7:0] == f0[8:1]) dec = SUP_CHARS[j];
      end
      total++;
      if (dec !== SUP_CHARS[k]) begin
        $display("FAIL loopback_decode: decoded %h required %h", dec, SUP_CHARS[k]);
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int t, base, vbase, fb, w, line_bad;
    fb = fall_cnt;
    handshake(8'h31, t, base, vbase);
    w = 0;
    while (fall_cnt < fb + 12 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (ps2_clk !== 1'b0 || fall_cnt != fb + 12) begin
      $display("FAIL rst_mid_setup: ps2_clk=%b falls=%0d required 0/12", ps2_clk, fall_cnt - fb);
      bad++;
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({ps2_clk, ps2_data, ascii_ready, busy, unsupported} !== 5'b11100) begin
      $display("FAIL rst_mid: {clk,data,rdy,busy,uns}=%b required 11100",
               {ps2_clk, ps2_data, ascii_ready, busy, unsupported});
      bad++;
    end
    rst      = 1'b0;
    fb       = fall_cnt;
    line_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || ascii_ready !== 1'b1 || busy !== 1'b0) line_bad++;
    end
    total++;
    if (line_bad != 0 || fall_cnt != fb) begin
      $display("FAIL rst_mid_quiet: %0d bad cycles, %0d edges, required 0/0",
               line_bad, fall_cnt - fb);
      bad++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_char_1();
    test_enter_and_nine();
    test_back_to_back();
    test_unsupported();
    test_random();
    test_loopback();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
